// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between EX and a single-beat data bus.
// Ports: clk, rst (sync, active-high); request side mem_req_valid, mem_we,
//   funct3, addr, wdata; pipeline side stall, done, data_from_MEM,
//   misalign, bus_err; bus side dbus_req/we/addr/wdata/be, dbus_ack/rdata.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_req_valid,
  input  logic            mem_we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] data_from_MEM,
  output logic            misalign,
  output logic            bus_err,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] data_q;
  logic            err_q;

  logic            legal;
  logic            start;
  logic            timeout;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_val;

  // Stores only exist as B/H/W; unsigned variants are load-only.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~mem_we;
      3'b101:  legal = ~mem_we & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign start    = (state == IDLE) & mem_req_valid & legal;
  assign misalign = (state == IDLE) & mem_req_valid & ~legal;
  assign stall    = start | (state == ACCESS);
  assign dbus_req = (state == ACCESS);
  assign dbus_we  = (state == ACCESS) & we_q;
  assign done     = (state == RESP);
  assign bus_err  = err_q;
  assign data_from_MEM = data_q;
  assign dbus_addr = {addr_q[XLEN-1:2], 2'b00};

  // An ack in the final allowed cycle takes precedence over the timeout.
  assign timeout = (state == ACCESS) & ~dbus_ack
                 & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (dbus_ack | timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        dbus_be    = 4'b0001 << addr_q[1:0];
        dbus_wdata = {(XLEN/8){wdata_q[7:0]}};
      end
      2'b01: begin
        dbus_be    = 4'b0011 << addr_q[1:0];
        dbus_wdata = {(XLEN/16){wdata_q[15:0]}};
      end
      default: begin
        dbus_be    = 4'b1111;
        dbus_wdata = wdata_q;
      end
    endcase
  end

  assign lane = dbus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = lane;
    case (f3_q)
      3'b000:  load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= timeout;
      if (start) begin
        cnt     <= '0;
        we_q    <= mem_we;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ACCESS) begin
        if (dbus_ack) begin
          if (!we_q) data_q <= load_val;
        end else if (timeout) begin
          data_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, reset sequence and random
// transactions for mem_access_unit against a reference model.
module tb_mem_access_unit;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] data_from_MEM;
  logic        misalign;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_we        (mem_we),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .done          (done),
    .data_from_MEM (data_from_MEM),
    .misalign      (misalign),
    .bus_err       (bus_err),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_wdata    (dbus_wdata),
    .dbus_be       (dbus_be),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_at;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_bwd;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  function automatic bit m_legal(logic [2:0] f3, logic we, logic [31:0] a);
    int sz;
    bit listed;
    listed = (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && f3 inside {3'd4, 3'd5});
    if (!listed) return 1'b0;
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a,
                                         logic [31:0] rd);
    longint v;
    int bits;
    if (f3[1:0] == 2'b10) return rd;
    bits = f3[0] ? 16 : 8;
    v = longint'(rd) >> (8 * int'(a[1:0]));
    v = v % (longint'(1) << bits);
    if (!f3[2] && v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // ack_at = 0 means the bus never acknowledges.
  task automatic run_txn(input vec_t v, input string nm);
    @(posedge clk); #1;
    mem_req_valid = 1'b1;
    mem_we = v.we;
    funct3 = v.f3;
    addr = v.a;
    wdata = v.wd;
    dbus_ack = 1'b0;
    #2;
    chk1({nm, ".misalign"}, misalign, v.e_mis);
    chk1({nm, ".req0"}, dbus_req, 1'b0);
    if (v.e_mis) begin
      chk1({nm, ".stall_mis"}, stall, 1'b0);
      @(posedge clk); #1;
      mem_req_valid = 1'b0;
      #2;
      chk1({nm, ".idle_req"}, dbus_req, 1'b0);
      return;
    end
    chk1({nm, ".stall0"}, stall, 1'b1);
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(posedge clk); #1;
      addr = $urandom;
      wdata = $urandom;
      funct3 = 3'($urandom);
      mem_we = 1'($urandom);
      dbus_ack = (c == v.ack_at);
      dbus_rdata = dbus_ack ? v.rd : $urandom;
      #2;
      chk1({nm, ".req"}, dbus_req, 1'b1);
      chk1({nm, ".stall"}, stall, 1'b1);
      chk1({nm, ".done_early"}, done, 1'b0);
      chk({nm, ".dbus_addr"}, dbus_addr, {v.a[31:2], 2'b00});
      chk1({nm, ".dbus_we"}, dbus_we, v.we);
      if (v.we) begin
        chk({nm, ".be"}, 32'(dbus_be), 32'(v.e_be));
        chk({nm, ".dbus_wdata"}, dbus_wdata, v.e_bwd);
      end
      if (c == v.ack_at) break;
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    mem_req_valid = 1'b1;
    mem_we = 1'b0;
    funct3 = 3'b010;
    addr = 32'h0;
    #2;
    chk1({nm, ".done"}, done, 1'b1);
    chk1({nm, ".stall_resp"}, stall, 1'b0);
    chk1({nm, ".req_resp"}, dbus_req, 1'b0);
    chk1({nm, ".bus_err"}, bus_err, v.e_err);
    chk({nm, ".data"}, data_from_MEM, v.e_data);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    #2;
    chk1({nm, ".done_off"}, done, 1'b0);
    chk1({nm, ".err_off"}, bus_err, 1'b0);
    chk1({nm, ".no_restart"}, dbus_req, 1'b0);
    chk1({nm, ".stall_idle"}, stall, 1'b0);
  endtask

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] mdata;
    int sz;
    int off;

    tbl[0]  = '{3'b000, 1'b0, 32'h103, 32'h0, 32'h80FF_FF00, 2,
                1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFF_FF80};
    tbl[1]  = '{3'b001, 1'b1, 32'h202, 32'h0000_ABCD, 32'h0, 1,
                1'b0, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'hFFFF_FF80};
    tbl[2]  = '{3'b010, 1'b0, 32'h101, 32'h0, 32'h0, 1,
                1'b1, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[3]  = '{3'b101, 1'b0, 32'h0, 32'h0, 32'h0, 0,
                1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[4]  = '{3'b101, 1'b0, 32'h0, 32'h0, 32'h1234_8765, 16,
                1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_8765};
    tbl[5]  = '{3'b001, 1'b0, 32'h2, 32'h0, 32'h8765_1234, 1,
                1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFF_8765};
    tbl[6]  = '{3'b100, 1'b0, 32'h1, 32'h0, 32'h0000_F000, 3,
                1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_00F0};
    tbl[7]  = '{3'b000, 1'b1, 32'h7, 32'h1234_56AB, 32'h0, 2,
                1'b0, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0000_00F0};
    tbl[8]  = '{3'b010, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1,
                1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_00F0};
    tbl[9]  = '{3'b010, 1'b0, 32'h14, 32'h0, 32'hCAFE_F00D, 4,
                1'b0, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D};
    tbl[10] = '{3'b001, 1'b1, 32'h1, 32'h0, 32'h0, 1,
                1'b1, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[11] = '{3'b100, 1'b1, 32'h0, 32'h0, 32'h0, 1,
                1'b1, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[12] = '{3'b011, 1'b0, 32'h0, 32'h0, 32'h0, 1,
                1'b1, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[13] = '{3'b110, 1'b0, 32'h0, 32'h0, 32'h0, 1,
                1'b1, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[14] = '{3'b000, 1'b0, 32'h0, 32'h0, 32'h0000_007F, 1,
                1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_007F};

    rst = 1'b1;
    mem_req_valid = 1'b0;
    mem_we = 1'b0;
    funct3 = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.done", done, 1'b0);
    chk1("rst.req", dbus_req, 1'b0);
    chk1("rst.bus_err", bus_err, 1'b0);
    chk1("rst.misalign", misalign, 1'b0);
    chk("rst.data", data_from_MEM, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the second ACCESS cycle, colliding with ack and a request.
    @(posedge clk); #1;
    mem_req_valid = 1'b1;
    mem_we = 1'b0;
    funct3 = 3'b010;
    addr = 32'h20;
    #2;
    chk1("mid.stall0", stall, 1'b1);
    @(posedge clk); #1;
    #2;
    chk1("mid.req1", dbus_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    dbus_ack = 1'b1;
    dbus_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b0;
    dbus_ack = 1'b0;
    addr = 32'h40;
    #2;
    chk1("mid.req", dbus_req, 1'b0);
    chk1("mid.done", done, 1'b0);
    chk1("mid.bus_err", bus_err, 1'b0);
    chk("mid.data", data_from_MEM, 32'h0);
    chk1("mid.stall_new", stall, 1'b1);
    mem_req_valid = 1'b0;
    #1;
    chk1("mid.stall_drop", stall, 1'b0);
    @(posedge clk); #3;
    chk1("mid.idle", dbus_req, 1'b0);

    mdata = 32'h0;
    for (int n = 0; n < 60; n++) begin
      v.f3 = 3'($urandom);
      v.we = 1'($urandom);
      v.a = $urandom;
      v.wd = $urandom;
      v.rd = $urandom;
      v.ack_at = $urandom_range(0, TIMEOUT);
      if (v.we && v.ack_at == 0) v.ack_at = 1;
      v.e_mis = !m_legal(v.f3, v.we, v.a);
      v.e_be = 4'h0;
      v.e_bwd = 32'h0;
      v.e_err = (v.ack_at == 0);
      if (!v.e_mis) begin
        sz = 1 << v.f3[1:0];
        off = int'(v.a[1:0]);
        v.e_be = 4'(((1 << sz) - 1) << off);
        if (sz == 1) v.e_bwd = 32'(v.wd[7:0]) * 32'h0101_0101;
        else if (sz == 2) v.e_bwd = 32'(v.wd[15:0]) * 32'h0001_0001;
        else v.e_bwd = v.wd;
        if (v.ack_at == 0) mdata = 32'h0;
        else if (!v.we) mdata = m_load(v.f3, v.a, v.rd);
      end
      v.e_data = mdata;
      run_txn(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
